spi_master_link: RTL and testbench

Master-side serial link controller for the encryption/decryption subnode. It takes a parallel message block and an expanded key schedule and shifts them out MSB-first on a single data line while holding chip-select low. It then waits a fixed processing window, shifts the processed block back in from the subnode's serial output and presents it in parallel. It sits in the master world, directly opposite the subnode, and is the only driver of the subnode's `sdi` and chip-select inputs.

---
 rtl/spi_master_link.sv | 161 ++++++++++++++++
 tb/tb_spi_master_link.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_link.sv
// spi_master_link
// Master-side serial link to the encryption/decryption subnode. A message
// block and its expanded key schedule are shifted out MSB-first on sdi_out
// while cs_out is low. After a fixed processing window the processed block
// is shifted back in from sdo_in and presented on result.
//
// Optional feature: define SPI_LINK_ABORT_EN to add the abort input.
//
// Ports:
//   in_clk     in   single clock, rising edge
//   rst        in   asynchronous active-high reset (also resets the subnode)
//   start      in   transfer request, sampled only in IDLE
//   msg_in     in   MSG_W-bit block, captured on the accepted start
//   key_in     in   KEY_W-bit key schedule, captured on the accepted start
//   sdo_in     in   serial response from the subnode
//   abort      in   (SPI_LINK_ABORT_EN only) drop the current transfer
//   sdi_out    out  serial data to the subnode
//   cs_out     out  chip-select, high = idle / subnode held in reset
//   busy       out  high from the accepted start until done
//   done       out  one-cycle pulse, result valid from this cycle
//   result     out  received block, held until replaced by a later done
//   state_dbg  out  current FSM state
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// FSM is IDLE (busy=0); start is ignored while busy=1. Completion is the
// single-cycle done pulse, in which busy is already low again.
module spi_master_link #(
   parameter int nk         = 8,
   parameter int nb         = 4,
   parameter int nr         = 14,
   parameter int RESP_DELAY = 24
) (
   input  logic                    in_clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [32*nb-1:0]        msg_in,
   input  logic [32*nb*(nr+1)-1:0] key_in,
   input  logic                    sdo_in,
`ifdef SPI_LINK_ABORT_EN
   input  logic                    abort,
`endif
   output logic                    sdi_out,
   output logic                    cs_out,
   output logic                    busy,
   output logic                    done,
   output logic [32*nb-1:0]        result,
   output logic [2:0]              state_dbg
);

   // nk does not shape any logic; it is folded in with weight zero so the
   // parameter set stays identical to the subnode's.
   localparam int MSG_W = 32*nb + 0*nk;
   localparam int KEY_W = 32*nb*(nr+1);

   localparam logic [15:0] MSG_LAST  = 16'(MSG_W - 1);
   localparam logic [15:0] KEY_LAST  = 16'(KEY_W - 1);
   localparam logic [15:0] WAIT_LAST = 16'(RESP_DELAY - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SEND_MSG = 3'd1;
   localparam logic [2:0] S_SEND_KEY = 3'd2;
   localparam logic [2:0] S_WAIT     = 3'd3;
   localparam logic [2:0] S_RECV     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]       state;
   logic [15:0]      cnt;
   // Holds the outgoing message, then (already drained to zero) collects
   // the response bits entering at the LSB.
   logic [MSG_W-1:0] shift_sr;
   logic [KEY_W-1:0] key_sr;
   logic             phase_end;
   logic             abort_hit;

`ifdef SPI_LINK_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // Last cycle of the current phase. DONE is a one-cycle phase so the
   // shared counter is also cleared on the way back to IDLE.
   always_comb begin
      phase_end = 1'b0;
      case (state)
         S_SEND_MSG: phase_end = (cnt == MSG_LAST);
         S_SEND_KEY: phase_end = (cnt == KEY_LAST);
         S_WAIT:     phase_end = (cnt == WAIT_LAST);
         S_RECV:     phase_end = (cnt == MSG_LAST);
         S_DONE:     phase_end = 1'b1;
         default:    phase_end = 1'b0;
      endcase
   end

   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         shift_sr <= '0;
         key_sr   <= '0;
         result   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_hit) begin
            // Abort wins over any phase completion; result is left alone.
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     shift_sr <= msg_in;
                     key_sr   <= key_in;
                     cnt      <= '0;
                     state    <= S_SEND_MSG;
                  end
               end
               S_SEND_MSG: begin
                  shift_sr <= {shift_sr[MSG_W-2:0], 1'b0};
                  if (phase_end) state <= S_SEND_KEY;
               end
               S_SEND_KEY: begin
                  key_sr <= {key_sr[KEY_W-2:0], 1'b0};
                  if (phase_end) state <= S_WAIT;
               end
               S_WAIT: begin
                  if (phase_end) state <= S_RECV;
               end
               S_RECV: begin
                  shift_sr <= {shift_sr[MSG_W-2:0], sdo_in};
                  if (phase_end) state <= S_DONE;
               end
               S_DONE: begin
                  result <= shift_sr;
                  done   <= 1'b1;
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
            if (state != S_IDLE) cnt <= phase_end ? 16'd0 : cnt + 16'd1;
         end
      end
   end

   // Outputs decode straight from registered state, so they only move on
   // rising edges and the subnode can sample mid-bit on the falling edge.
   always_comb begin
      sdi_out = 1'b0;
      case (state)
         S_SEND_MSG: sdi_out = shift_sr[MSG_W-1];
         S_SEND_KEY: sdi_out = key_sr[KEY_W-1];
         default:    sdi_out = 1'b0;
      endcase
   end

   assign cs_out    = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_spi_master_link.sv
// tb_spi_master_link
// Directed bench for spi_master_link. A timeline model (cycles since the
// accepting edge) predicts cs_out/busy/done/sdi_out/result every cycle; a
// subnode model drives sdo_in inside the response window; completed blocks
// are checked against an expected queue. Hand-computed literals pin the
// serial stream shape, the done latency and reset behaviour.
module tb_spi_master_link;

   localparam int NK         = 8;
   localparam int NB         = 4;
   localparam int NR         = 14;
   localparam int RESP_DELAY = 24;
   localparam int MSG_W      = 32*NB;
   localparam int KEY_W      = 32*NB*(NR+1);
   localparam int STREAM_W   = MSG_W + KEY_W;
   localparam int RX_FIRST   = STREAM_W + RESP_DELAY + 1;
   localparam int DONE_EDGE  = 2*MSG_W + KEY_W + RESP_DELAY + 1;

   localparam logic [MSG_W-1:0] MSG_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [MSG_W-1:0] RESP_A = 128'hdeadbeef_00000000_cafef00d_12345678;

   // ---------------- clock / reset / DUT ----------------
   logic             in_clk;
   logic             rst;
   logic             start;
   logic [MSG_W-1:0] msg_in;
   logic [KEY_W-1:0] key_in;
   logic             sdo_in;
   logic             sdi_out;
   logic             cs_out;
   logic             busy;
   logic             done;
   logic [MSG_W-1:0] result;
   logic [2:0]       state_dbg;
`ifdef SPI_LINK_ABORT_EN
   logic             abort;
`endif

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   spi_master_link #(.nk(NK), .nb(NB), .nr(NR), .RESP_DELAY(RESP_DELAY)) dut (
      .in_clk    (in_clk),
      .rst       (rst),
      .start     (start),
      .msg_in    (msg_in),
      .key_in    (key_in),
      .sdo_in    (sdo_in),
`ifdef SPI_LINK_ABORT_EN
      .abort     (abort),
`endif
      .sdi_out   (sdi_out),
      .cs_out    (cs_out),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;

   logic [MSG_W-1:0] exp_q[$];
   logic [MSG_W-1:0] resp_q[$];

   bit                  m_active = 1'b0;
   int                  m_t      = 0;
   logic [STREAM_W-1:0] m_stream;
   logic [MSG_W-1:0]    m_rx;
   logic [MSG_W-1:0]    m_resp   = '0;
   logic [MSG_W-1:0]    m_result = '0;
   logic                m_done   = 1'b0;
   int                  edge_n   = 0;
   int                  e0_edge  = 0;
   int                  accept_cnt = 0;
   int                  done_cnt   = 0;
   int                  last_done_edge = 0;
   bit                  log_en = 1'b0;
   logic                sdi_log [0:STREAM_W-1];

   task automatic chk(input string name, input logic [MSG_W-1:0] act,
                      input logic [MSG_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- timeline model + per-cycle compare ----------------
   initial begin
      logic exp_sdi;
      logic abort_now;
      forever begin
         @(posedge in_clk);
         edge_n++;
         abort_now = 1'b0;
`ifdef SPI_LINK_ABORT_EN
         abort_now = abort;
`endif
         if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_result = '0;
         end else begin
            m_done = 1'b0;
            if (abort_now && m_active) begin
               m_active = 1'b0;
            end else if (m_active) begin
               m_t++;
               if (m_t >= RX_FIRST && m_t < RX_FIRST + MSG_W)
                  m_rx[MSG_W-1-(m_t-RX_FIRST)] = sdo_in;
               if (m_t == DONE_EDGE) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
                  m_result = m_rx;
               end
            end else if (start) begin
               m_active = 1'b1;
               m_t      = 0;
               m_stream = {msg_in, key_in};
               m_rx     = '0;
               e0_edge  = edge_n;
               accept_cnt++;
               if (resp_q.size() > 0) m_resp = resp_q.pop_front();
               else m_resp = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         #1;
         exp_sdi = (m_active && m_t < STREAM_W) ? m_stream[STREAM_W-1-m_t] : 1'b0;
         chk($sformatf("ctl{cs,busy,done,sdi}@%0d", edge_n),
             {cs_out, busy, done, sdi_out}, {!m_active, m_active, m_done, exp_sdi});
         chk($sformatf("result@%0d", edge_n), result, m_result);
         if (log_en && m_active && m_t < STREAM_W) sdi_log[m_t] = sdi_out;
         if (done === 1'b1) begin
            done_cnt++;
            last_done_edge = edge_n;
            if (exp_q.size() == 0) chk($sformatf("unexpected_done@%0d", edge_n), 1, 0);
            else chk("done_result", result, exp_q.pop_front());
         end
      end
   end

   // ---------------- subnode model ----------------
   // Presents response bit k before sample edge RX_FIRST+k; noise elsewhere.
   initial begin
      int k;
      sdo_in = 1'b0;
      forever begin
         @(negedge in_clk);
         k = m_t + 1 - RX_FIRST;
         if (m_active && k >= 0 && k < MSG_W) sdo_in = m_resp[MSG_W-1-k];
         else sdo_in = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept(input string name, input int budget);
      int base;
      int n;
      base = accept_cnt;
      n = 0;
      while (accept_cnt == base && n < budget) begin
         @(negedge in_clk);
         n++;
      end
      chk(name, (accept_cnt != base), 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int base;
      int n;
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge in_clk);
         n++;
      end
      chk(name, (done_cnt != base), 1);
   endtask

   task automatic rand_inputs(output logic [MSG_W-1:0] resp);
      msg_in = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < KEY_W/32; i++) key_in[i*32 +: 32] = $urandom;
      resp = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run_to_edge(input int target);
      int n;
      n = 0;
      while (edge_n < target && n < 5000) begin
         @(negedge in_clk);
         n++;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int e0a, e0b, e0d, e0e, ones, base_done;
      logic [7:0] first_byte, last_byte;
      logic [MSG_W-1:0] resp_b, resp_c, resp_d, resp_e;

      rst = 1'b1;
      start = 1'b0;
      msg_in = '0;
      key_in = '0;
`ifdef SPI_LINK_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge in_clk);
      chk("reset_cs", cs_out, 1);
      chk("reset_sdi", sdi_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      rst = 1'b0;
      repeat (2) @(negedge in_clk);

      // A: serialization and response capture, with a start pulse mid-run
      msg_in = MSG_A;
      key_in = '1;
      key_in[0] = 1'b0;
      resp_q.push_back(RESP_A);
      exp_q.push_back(RESP_A);
      log_en = 1'b1;
      start = 1'b1;
      wait_accept("accept_a", 4);
      start = 1'b0;
      e0a = e0_edge;
      run_to_edge(e0a + 499);
      start = 1'b1;
      @(negedge in_clk);
      start = 1'b0;
      wait_done("done_a", 2500);
      log_en = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("accepts_after_a", accept_cnt, 1);
      chk("dones_after_a", done_cnt, 1);
      chk("done_latency_a", last_done_edge - e0a, 2201);
      chk("result_a", result, RESP_A);
      first_byte = '0;
      last_byte  = '0;
      for (int i = 0; i < 8; i++) begin
         first_byte = {first_byte[6:0], sdi_log[i]};
         last_byte  = {last_byte[6:0], sdi_log[120+i]};
      end
      chk("sdi_first_byte", first_byte, 8'h00);
      chk("sdi_last_msg_byte", last_byte, 8'hff);
      ones = 0;
      for (int i = 128; i < 2047; i++) if (sdi_log[i] === 1'b1) ones++;
      chk("sdi_key_ones", ones, 1919);
      chk("sdi_last_key_bit", sdi_log[2047], 0);

      // B: asynchronous reset mid-clock at E0+1000
      rand_inputs(resp_b);
      resp_q.push_back(resp_b);
      start = 1'b1;
      wait_accept("accept_b", 4);
      start = 1'b0;
      e0b = e0_edge;
      run_to_edge(e0b + 1000);
      #2 rst = 1'b1;
      #1;
      chk("midrst_cs", cs_out, 1);
      chk("midrst_sdi", sdi_out, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      @(negedge in_clk);
      rst = 1'b0;
      base_done = done_cnt;
      repeat (20) @(negedge in_clk);
      chk("no_done_after_rst", done_cnt, base_done);

      // C: clean transfer after the reset
      rand_inputs(resp_c);
      resp_q.push_back(resp_c);
      exp_q.push_back(resp_c);
      start = 1'b1;
      wait_accept("accept_c", 4);
      start = 1'b0;
      wait_done("done_c", 2500);
      @(negedge in_clk);
      chk("result_c", result, resp_c);

      // D, E: back-to-back with start held high
      rand_inputs(resp_d);
      resp_e = {$urandom, $urandom, $urandom, $urandom};
      resp_q.push_back(resp_d);
      resp_q.push_back(resp_e);
      exp_q.push_back(resp_d);
      exp_q.push_back(resp_e);
      start = 1'b1;
      wait_accept("accept_d", 4);
      e0d = e0_edge;
      wait_done("done_d", 2500);
      wait_accept("accept_e", 4);
      e0e = e0_edge;
      start = 1'b0;
      chk("b2b_spacing", e0e - e0d, 2202);
      wait_done("done_e", 2500);
      @(negedge in_clk);
      chk("result_e", result, resp_e);

`ifdef SPI_LINK_ABORT_EN
      // F: abort during the processing window
      begin
         int e0f;
         logic [MSG_W-1:0] resp_f;
         rand_inputs(resp_f);
         resp_q.push_back(resp_f);
         start = 1'b1;
         wait_accept("accept_f", 4);
         start = 1'b0;
         e0f = e0_edge;
         run_to_edge(e0f + 2059);
         abort = 1'b1;
         @(negedge in_clk);
         abort = 1'b0;
         chk("abort_cs", cs_out, 1);
         chk("abort_busy", busy, 0);
         chk("abort_result", result, resp_e);
         base_done = done_cnt;
         repeat (200) @(negedge in_clk);
         chk("abort_no_done", done_cnt, base_done);
      end
`endif

      repeat (5) @(negedge in_clk);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_total", done_cnt, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
